// File: rtl/pwm_channel_ctrl.sv
// Complementary PWM output stage: preload/active ARR and CCR, update event,
// CNT-vs-CCR compare and dead-time insertion with programmable polarity.
module pwm_channel_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                PWM_EN,
  input  logic                mode,
  input  logic [WIDTH-1:0]    CNT,
  input  logic [WIDTH-1:0]    ARR_PRE,
  input  logic [WIDTH-1:0]    CCR_PRE,
  input  logic                PRELOAD_EN,
  input  logic                POL,
  input  logic [DT_WIDTH-1:0] DTG,
  output logic [WIDTH-1:0]    ARR_ACT,
  output logic [WIDTH-1:0]    CCR_ACT,
  output logic                UEV,
  output logic                PWM_H,
  output logic                PWM_L
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    H_ON    = 3'd1,
    L_ON    = 3'd2,
    DT_TO_H = 3'd3,
    DT_TO_L = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DT_WIDTH-1:0] dt_cnt;
  logic [DT_WIDTH-1:0] dt_cnt_nxt;
  logic                ref_q;
  logic                uev_c;
  logic                load_c;
  logic                dtg_zero_c;

  // Update event: last count before wrap (up) or the valley (up-down).
  assign uev_c      = PWM_EN & tick & ((~mode & (CNT >= ARR_ACT)) | (mode & (CNT == '0)));
  assign load_c     = ~PWM_EN | ~PRELOAD_EN | uev_c;
  assign dtg_zero_c = (DTG == '0);

  // Active period/compare registers, update pulse and compare reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ARR_ACT <= '0;
      CCR_ACT <= '0;
      UEV     <= 1'b0;
      ref_q   <= 1'b0;
    end else begin
      if (load_c) begin
        ARR_ACT <= ARR_PRE;
        CCR_ACT <= CCR_PRE;
      end
      UEV   <= uev_c;
      ref_q <= PWM_EN & (CNT < CCR_ACT);
    end
  end

  // Dead-time next-state logic; a reference flip during dead time restarts it toward the other side.
  always_comb begin
    state_nxt  = state;
    dt_cnt_nxt = dt_cnt;
    if (!PWM_EN) begin
      state_nxt = OFF;
    end else begin
      case (state)
        OFF: state_nxt = ref_q ? H_ON : L_ON;
        L_ON: begin
          if (ref_q) begin
            if (dtg_zero_c) begin
              state_nxt = H_ON;
            end else begin
              state_nxt  = DT_TO_H;
              dt_cnt_nxt = DTG;
            end
          end
        end
        H_ON: begin
          if (!ref_q) begin
            if (dtg_zero_c) begin
              state_nxt = L_ON;
            end else begin
              state_nxt  = DT_TO_L;
              dt_cnt_nxt = DTG;
            end
          end
        end
        DT_TO_H: begin
          if (!ref_q) begin
            if (dtg_zero_c) begin
              state_nxt = L_ON;
            end else begin
              state_nxt  = DT_TO_L;
              dt_cnt_nxt = DTG;
            end
          end else if (dt_cnt <= DT_WIDTH'(1)) begin
            state_nxt = H_ON;
          end else begin
            dt_cnt_nxt = dt_cnt - DT_WIDTH'(1);
          end
        end
        DT_TO_L: begin
          if (ref_q) begin
            if (dtg_zero_c) begin
              state_nxt = H_ON;
            end else begin
              state_nxt  = DT_TO_H;
              dt_cnt_nxt = DTG;
            end
          end else if (dt_cnt <= DT_WIDTH'(1)) begin
            state_nxt = L_ON;
          end else begin
            dt_cnt_nxt = dt_cnt - DT_WIDTH'(1);
          end
        end
        default: state_nxt = OFF;
      endcase
    end
  end

  // State register; outputs are registered from the next state so they never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      dt_cnt <= '0;
      PWM_H  <= 1'b0;
      PWM_L  <= 1'b0;
    end else begin
      state  <= state_nxt;
      dt_cnt <= dt_cnt_nxt;
      PWM_H  <= POL ^ (state_nxt == H_ON);
      PWM_L  <= POL ^ (state_nxt == L_ON);
    end
  end

endmodule

// File: tb/tb_pwm_channel_ctrl.sv
// Bench for pwm_channel_ctrl: directed waveform scenarios plus random stimulus,
// all checked cycle by cycle against a run-length reference model.
module tb_pwm_channel_ctrl;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DT_WIDTH = 8;

  logic                clk;
  logic                rst_n;
  logic                tick;
  logic                pwm_en;
  logic                mode;
  logic                preload_en;
  logic                pol;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    arr_pre;
  logic [WIDTH-1:0]    ccr_pre;
  logic [DT_WIDTH-1:0] dtg;
  logic [WIDTH-1:0]    arr_act;
  logic [WIDTH-1:0]    ccr_act;
  logic                uev;
  logic                pwm_h;
  logic                pwm_l;

  pwm_channel_ctrl #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .PWM_EN    (pwm_en),
    .mode      (mode),
    .CNT       (cnt),
    .ARR_PRE   (arr_pre),
    .CCR_PRE   (ccr_pre),
    .PRELOAD_EN(preload_en),
    .POL       (pol),
    .DTG       (dtg),
    .ARR_ACT   (arr_act),
    .CCR_ACT   (ccr_act),
    .UEV       (uev),
    .PWM_H     (pwm_h),
    .PWM_L     (pwm_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an output side turns on once the reference has held its
  // new value for the dead time latched at the change.
  logic [WIDTH-1:0] m_arr, m_ccr;
  logic             m_uev, m_ref, m_h, m_l, m_off, m_last_ref;
  int               m_run, m_dt;
  logic             c_down, auto_cnt;
  logic [WIDTH-1:0] cnt_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_arr = '0; m_ccr = '0; m_uev = 1'b0; m_ref = 1'b0;
    m_h = 1'b0; m_l = 1'b0; m_off = 1'b1; m_last_ref = 1'b0;
    m_run = 0; m_dt = 0; c_down = 1'b0;
  endtask

  task automatic model_clock();
    logic uev_e, h_act, l_act;
    uev_e = pwm_en && tick && (mode ? (cnt == '0) : (cnt >= m_arr));
    // counter stimulus, fed by the model's active period
    cnt_next = cnt;
    if (!pwm_en) begin
      cnt_next = '0;
      c_down   = 1'b0;
    end else if (tick) begin
      if (!mode) begin
        cnt_next = (cnt >= m_arr) ? '0 : WIDTH'(cnt + 1);
      end else if (!c_down) begin
        if (cnt >= m_arr) begin
          if (m_arr != '0) begin
            c_down   = 1'b1;
            cnt_next = WIDTH'(cnt - 1);
          end else begin
            cnt_next = '0;
          end
        end else begin
          cnt_next = WIDTH'(cnt + 1);
        end
      end else if (cnt == '0) begin
        c_down   = 1'b0;
        cnt_next = (m_arr == '0) ? '0 : WIDTH'(1);
      end else begin
        cnt_next = WIDTH'(cnt - 1);
      end
    end
    h_act = 1'b0;
    l_act = 1'b0;
    if (pwm_en) begin
      if (m_off) begin
        m_last_ref = m_ref; m_run = 0; m_dt = 0;
      end else if (m_ref != m_last_ref) begin
        m_last_ref = m_ref; m_run = 0; m_dt = int'(dtg);
      end else if (m_run < 1000) begin
        m_run++;
      end
      if (m_run >= m_dt) begin
        h_act = m_ref;
        l_act = !m_ref;
      end
    end
    m_off = !pwm_en;
    m_h   = pol ^ h_act;
    m_l   = pol ^ l_act;
    m_ref = pwm_en && (cnt < m_ccr);
    m_uev = uev_e;
    if (!pwm_en || !preload_en || uev_e) begin
      m_arr = arr_pre;
      m_ccr = ccr_pre;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("arr_act", arr_act, m_arr);
    chk("ccr_act", ccr_act, m_ccr);
    chk("uev", uev, m_uev);
    chk("pwm_h", pwm_h, m_h);
    chk("pwm_l", pwm_l, m_l);
    chk("overlap", 32'((pwm_h == ~pol) && (pwm_l == ~pol)), 0);
    if (auto_cnt) cnt = cnt_next;
  endtask

  task automatic window(input string tag, input int n, input int exp_h, input int exp_l, input int exp_u);
    int nh = 0;
    int nl = 0;
    int nu = 0;
    for (int i = 0; i < n; i++) begin
      step();
      nh += int'(pwm_h == ~pol);
      nl += int'(pwm_l == ~pol);
      nu += int'(uev);
    end
    chk({tag, "_h_active"}, nh, exp_h);
    chk({tag, "_l_active"}, nl, exp_l);
    chk({tag, "_uev_count"}, nu, exp_u);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    rst_n = 1'b0; tick = 1'b0; pwm_en = 1'b0; mode = 1'b0; preload_en = 1'b1;
    pol = 1'b0; cnt = '0; arr_pre = 16'd9; ccr_pre = 16'd4; dtg = '0; auto_cnt = 1'b1;
    model_reset();
    #12;
    chk("reset_arr", arr_act, 0);
    chk("reset_ccr", ccr_act, 0);
    chk("reset_uev", uev, 0);
    chk("reset_h", pwm_h, 0);
    chk("reset_l", pwm_l, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Up mode, no dead time, then DTG=2
    tick = 1'b1; pwm_en = 1'b1;
    repeat (25) step();
    window("up_dt0", 10, 4, 6, 1);
    dtg = 8'd2;
    repeat (20) step();
    window("up_dt2", 10, 2, 4, 1);

    // Preload: CCR change at CNT=3 waits for the update event
    dtg = 8'd0;
    repeat (20) step();
    for (int i = 0; i < 40 && cnt != 16'd3; i++) step();
    chk("find_cnt3", cnt, 3);
    ccr_pre = 16'd7;
    step();
    chk("ccr_hold", ccr_act, 4);
    repeat (5) step();
    chk("ccr_hold_late", ccr_act, 4);
    step();
    chk("ccr_uev_load", ccr_act, 7);
    chk("uev_at_load", uev, 1);
    repeat (10) step();
    window("preload7", 10, 7, 3, 1);
    preload_en = 1'b0; ccr_pre = 16'd2;
    step();
    chk("ccr_direct", ccr_act, 2);

    // Up-down mode
    preload_en = 1'b1; pwm_en = 1'b0;
    step();
    mode = 1'b1; arr_pre = 16'd5; ccr_pre = 16'd2;
    step();
    pwm_en = 1'b1;
    repeat (25) step();
    window("updown", 10, 3, 7, 1);

    // Compare boundaries and polarity
    pwm_en = 1'b0; mode = 1'b0; arr_pre = 16'd9; ccr_pre = 16'd0;
    step();
    pwm_en = 1'b1;
    repeat (15) step();
    window("ccr0", 20, 0, 20, 2);
    ccr_pre = 16'd10; preload_en = 1'b0;
    repeat (5) step();
    window("ccr_full", 20, 20, 0, 2);
    pol = 1'b1;
    repeat (3) step();
    chk("pol1_h_level", pwm_h, 0);
    ccr_pre = 16'd4; preload_en = 1'b1;
    repeat (20) step();
    window("pol1_wave", 10, 4, 6, 1);
    pwm_en = 1'b0;
    step();
    chk("dis_h_pol1", pwm_h, 1);
    chk("dis_l_pol1", pwm_l, 1);

    // Async reset in the third dead-time clock toward H
    dtg = 8'd5; ccr_pre = 16'd8;
    step();
    pwm_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      found = !m_off && m_last_ref && (m_dt == 5) && (m_run == 2);
    end
    chk("dt_to_h_reached", found, 1);
    chk("dead_h", pwm_h, 1);
    chk("dead_l", pwm_l, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_h", pwm_h, 0);
    chk("rst_mid_l", pwm_l, 0);
    chk("rst_mid_arr", arr_act, 0);
    pwm_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_h", pwm_h, 1);
    chk("rel_l", pwm_l, 1);
    pwm_en = 1'b1;
    repeat (40) step();
    window("restart", 10, 3, 0, 1);

    // Random stimulus with free-running CNT values
    auto_cnt = 1'b0; pol = 1'b0; dtg = 8'd3;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) cnt = WIDTH'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) ccr_pre = WIDTH'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) arr_pre = WIDTH'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) dtg = DT_WIDTH'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) pol = ~pol;
      if ($urandom_range(0, 39) == 0) pwm_en = ~pwm_en;
      if ($urandom_range(0, 29) == 0) preload_en = ~preload_en;
      tick = ($urandom_range(0, 3) != 0);
      mode = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_channel_ctrl.md
Name: pwm_channel_ctrl

Overview:
- Output stage that sits directly downstream of pwm_counter.
- Holds preload/active (shadow) copies of ARR and CCR, generates the update event (UEV), and compares CNT against the active CCR.
- Drives a complementary pair PWM_H/PWM_L with programmable dead-time and polarity.
- ARR_ACT feeds back into pwm_counter's ARR input, so the counter and the compare always use the same period.

Parameters:
- WIDTH, 16, counter/compare width (must match pwm_counter).
- DT_WIDTH, 8, dead-time counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  counter clock enable (same signal fed to pwm_counter)
- PWM_EN  in  1  channel enable (same signal fed to pwm_counter)
- mode  in  1  0: up, 1: up-down (same as pwm_counter)
- CNT  in  WIDTH  counter value from pwm_counter
- ARR_PRE  in  WIDTH  preload period
- CCR_PRE  in  WIDTH  preload compare
- PRELOAD_EN  in  1  1: load active regs only on UEV; 0: load every clk
- POL  in  1  0: outputs active-high, 1: active-low
- DTG  in  DT_WIDTH  dead-time, in clk cycles
- ARR_ACT  out  WIDTH  active period, to pwm_counter.ARR
- CCR_ACT  out  WIDTH  active compare
- UEV  out  1  update-event pulse, 1 clk wide
- PWM_H  out  1  high-side output
- PWM_L  out  1  low-side output

Behaviour:

Reset:
- ARR_ACT=0, CCR_ACT=0, UEV=0, ref_q=0, state=OFF, PWM_H=0, PWM_L=0.

Update condition:
- uev_c = PWM_EN & tick & ((mode==0 & CNT>=ARR_ACT) | (mode==1 & CNT==0)).
- In up mode this is the last count before wrap. In up-down mode it is the valley.

Active registers:
- PWM_EN=0 or PRELOAD_EN=0: ARR_ACT<=ARR_PRE and CCR_ACT<=CCR_PRE every clk.
- Otherwise they load only on an edge where uev_c=1.
- UEV<=uev_c registered, so it is high for exactly one clk after the qualifying edge.

Reference signal:
- ref_q <= PWM_EN & (CNT < CCR_ACT), unsigned compare, registered every clk.
- CCR_ACT=0 gives ref_q constantly 0.
- CCR_ACT>ARR_ACT gives ref_q constantly 1 while enabled.

Dead-time FSM:
- States: OFF, H_ON, L_ON, DT_TO_H, DT_TO_L. Counter dt_cnt is DT_WIDTH wide.
- OFF: go to H_ON if ref_q=1, else L_ON. No dead-time, since both outputs are already inactive.
- L_ON & ref_q=1: if DTG==0 go to H_ON; else go to DT_TO_H with dt_cnt<=DTG.
- H_ON & ref_q=0: if DTG==0 go to L_ON; else go to DT_TO_L with dt_cnt<=DTG.
- DT_TO_x: decrement each clk; when dt_cnt reaches 1, move to x_ON.
- If ref_q flips during DT_TO_x, switch to DT_TO_(other) and reload dt_cnt<=DTG. Both outputs stay inactive throughout.
- DTG is sampled only on entry to a DT state; later changes are ignored until the next transition.
- PWM_EN=0 forces state OFF on the next edge, overriding every other transition.

Outputs:
- Registered from the next state: PWM_H<=POL^(next==H_ON), PWM_L<=POL^(next==L_ON).
- When disabled, both outputs sit at the inactive level (=POL), reached one clk after PWM_EN falls.
- PWM_H and PWM_L are never active in the same cycle, for any input sequence.

Latency:
- CNT to ref_q: 1 clk. ref_q to outputs: 1 clk, plus DTG cycles for the turning-on side.
- The turning-off side goes inactive 1 clk after the ref_q change.
- Both sides are inactive for exactly DTG clk on each clean transition.

Reset mid-operation:
- Asynchronous reset takes effect immediately, from any state including DT_TO_x.
- After reset release the FSM passes through OFF. ARR_ACT/CCR_ACT are then reloaded from preload (PWM_EN=0 or PRELOAD_EN=0) or at the next UEV.

Test Plan:
1. Up mode: tick=1, ARR_PRE=9, CCR_PRE=4, DTG=0, POL=0, PRELOAD_EN=1, enable. -> Period 10 clk; PWM_H high 4 clk, PWM_L high 6 clk, complementary; UEV pulses once per 10 clk, the clk after CNT=9.
2. Same as 1 with DTG=2. -> PWM_H high 2 clk, PWM_L high 4 clk, two 2-clk gaps with both low; never both high.
3. Preload: PRELOAD_EN=1, change CCR_PRE 4→7 while CNT=3. -> Current period keeps CCR_ACT=4; CCR_ACT=7 from the edge where CNT=9 (UEV); the next period shows PWM_H high 7 clk. With PRELOAD_EN=0, CCR_ACT changes the next clk.
4. Up-down: mode=1, ARR=5, CCR=2, DTG=0. -> Period 10 clk; PWM_H high 3 contiguous clk (CNT 1,0,1 around the valley, delayed 2 clk); UEV the clk after CNT=0.
5. Boundaries: CCR_PRE=0 -> PWM_L constant active, PWM_H never. CCR_PRE=ARR_PRE+1 -> PWM_H constant active. POL=1 -> both waveforms inverted; disabled level 1/1.
6. Assert rst_n=0 during DT_TO_H (DTG=5, third dead clk) -> outputs 0 immediately. Release with PWM_EN=0 -> PWM_H=PWM_L=POL; re-enable -> clean restart through OFF with no overlap.
